// File: rtl/counter_pkg.sv
// Shared definitions for the mode_counter family of timers/prescalers.
package counter_pkg;

    // Default counter width for instances that do not override N.
    localparam int unsigned CNT_W_DEFAULT = 4;

    // Encodings of the mode_i and dir_i control inputs.
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;

    // Action selected for the current edge, in priority order clr > load > count.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLR   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_COUNT = 2'd3
    } cnt_op_e;

endpackage : counter_pkg

// File: rtl/mode_counter.sv
// Up/down modulo counter with wrap or one-shot mode, synchronous clear/load,
// registered terminal-count pulse, compare-match flag and sticky done flag.
module mode_counter
    import counter_pkg::*;
#(
    parameter int unsigned    N       = CNT_W_DEFAULT,
    parameter logic [N-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         dir_i,
    input  logic         mode_i,
    input  logic [N-1:0] max_i,
    input  logic [N-1:0] cmp_val_i,
    output logic [N-1:0] counter_o,
    output logic         tc_o,
    output logic         cmp_match_o,
    output logic         done_o
);

    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [N-1:0] counter_q, counter_d;
    logic         tc_q, tc_d;
    logic         cmp_match_q, cmp_match_d;
    logic         done_q, done_d;
    cnt_op_e      op;
    logic         at_terminal;

    // Select this edge's action; a finished one-shot ignores en_i.
    always_comb begin
        op = OP_HOLD;
        if (clr_i) begin
            op = OP_CLR;
        end else if (load_i) begin
            op = OP_LOAD;
        end else if (en_i && !done_q) begin
            op = OP_COUNT;
        end
    end

    // Terminal condition depends on direction; values above max_i count as terminal when going up.
    always_comb begin
        if (dir_i == DIR_UP) begin
            at_terminal = (counter_q >= max_i);
        end else begin
            at_terminal = (counter_q == '0);
        end
    end

    // Next-state computation for count, done, terminal pulse and compare flag.
    always_comb begin
        counter_d = counter_q;
        done_d    = done_q;
        tc_d      = 1'b0;
        unique case (op)
            OP_CLR: begin
                counter_d = RST_VAL;
                done_d    = 1'b0;
            end
            OP_LOAD: begin
                counter_d = load_val_i;
                done_d    = 1'b0;
            end
            OP_COUNT: begin
                if (at_terminal) begin
                    tc_d = 1'b1;
                    if (mode_i == MODE_WRAP) begin
                        counter_d = (dir_i == DIR_UP) ? '0 : max_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (dir_i == DIR_UP) begin
                    counter_d = counter_q + CNT_ONE;
                end else begin
                    counter_d = counter_q - CNT_ONE;
                end
            end
            default: begin
                counter_d = counter_q;
            end
        endcase
        // Compared against the next value so the flag lines up with counter_o.
        cmp_match_d = (counter_d == cmp_val_i);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            counter_q   <= RST_VAL;
            tc_q        <= 1'b0;
            cmp_match_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            tc_q        <= tc_d;
            cmp_match_q <= cmp_match_d;
            done_q      <= done_d;
        end
    end

    assign counter_o   = counter_q;
    assign tc_o        = tc_q;
    assign cmp_match_o = cmp_match_q;
    assign done_o      = done_q;

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter: directed scenarios plus randomized
// traffic compared against a behavioural model.
module tb_mode_counter;

    localparam int N    = 4;
    localparam int MODV = 16;
    localparam int RSTV = 3;

    logic         clk;
    logic         arst_n;
    logic         en_i, clr_i, load_i, dir_i, mode_i;
    logic [N-1:0] load_val_i, max_i, cmp_val_i;
    logic [N-1:0] counter_o;
    logic         tc_o, cmp_match_o, done_o;

    int n_cmp;
    int n_err;

    // Reference model state
    int m_cnt;
    bit m_done;
    bit m_tc;
    bit m_cmp;

    mode_counter #(
        .N       (N),
        .RST_VAL (4'(RSTV))
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .load_i      (load_i),
        .load_val_i  (load_val_i),
        .dir_i       (dir_i),
        .mode_i      (mode_i),
        .max_i       (max_i),
        .cmp_val_i   (cmp_val_i),
        .counter_o   (counter_o),
        .tc_o        (tc_o),
        .cmp_match_o (cmp_match_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cnt"},  32'(counter_o),   32'(m_cnt));
        check({tag, ".tc"},   32'(tc_o),        32'(m_tc));
        check({tag, ".cmp"},  32'(cmp_match_o), 32'(m_cmp));
        check({tag, ".done"}, 32'(done_o),      32'(m_done));
    endtask

    task automatic model_reset();
        m_cnt  = RSTV;
        m_done = 0;
        m_tc   = 0;
        m_cmp  = 0;
    endtask

    // Apply the rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        int mx;
        mx   = int'(max_i);
        m_tc = 0;
        if (clr_i) begin
            m_cnt  = RSTV;
            m_done = 0;
        end else if (load_i) begin
            m_cnt  = int'(load_val_i);
            m_done = 0;
        end else if (en_i && !m_done) begin
            if (dir_i) begin
                if (m_cnt >= mx) begin
                    m_tc = 1;
                    if (!mode_i) m_cnt = 0;
                    else         m_done = 1;
                end else begin
                    m_cnt = (m_cnt + 1) % MODV;
                end
            end else begin
                if (m_cnt == 0) begin
                    m_tc = 1;
                    if (!mode_i) m_cnt = mx;
                    else         m_done = 1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
        m_cmp = (m_cnt == int'(cmp_val_i));
    endtask

    task automatic drive(input bit en, input bit clr, input bit ld, input int lv,
                         input bit dir, input bit mode, input int mx, input int cv);
        en_i       = en;
        clr_i      = clr;
        load_i     = ld;
        load_val_i = 4'(lv);
        dir_i      = dir;
        mode_i     = mode;
        max_i      = 4'(mx);
        cmp_val_i  = 4'(cv);
    endtask

    task automatic cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    // Pulse the asynchronous reset between edges and verify outputs drop without a clock.
    task automatic async_reset(input string tag);
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        arst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 5, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        arst_n = 1'b1;

        // Hold after reset: cmp flag reflects RST_VAL == cmp_val_i
        drive(0, 0, 0, 0, 1, 0, 5, RSTV);
        cycles("hold_rst", 2);
        check("hold_rst.cmp_const", 32'(cmp_match_o), 32'd1);

        // Up wrap, max 5, start at 0
        drive(0, 0, 1, 0, 1, 0, 5, 9);
        cycles("up_load", 1);
        drive(1, 0, 0, 0, 1, 0, 5, 9);
        cycles("up_wrap", 14);

        // Down wrap, max 3, from 2 then from 9 (above max)
        drive(0, 0, 1, 2, 0, 0, 3, 15);
        cycles("dn_load2", 1);
        drive(1, 0, 0, 0, 0, 0, 3, 15);
        cycles("dn_wrap", 7);
        drive(0, 0, 1, 9, 0, 0, 3, 15);
        cycles("dn_load9", 1);
        drive(1, 0, 0, 0, 0, 0, 3, 15);
        cycles("dn_above", 12);

        // One-shot up, max 4
        drive(0, 0, 1, 0, 1, 1, 4, 15);
        cycles("os_load", 1);
        drive(1, 0, 0, 0, 1, 1, 4, 15);
        cycles("os_run", 9);
        check("os_done_const", 32'(done_o), 32'd1);
        check("os_hold_const", 32'(counter_o), 32'd4);
        drive(0, 0, 1, 0, 1, 1, 4, 15);
        cycles("os_reload", 1);
        drive(1, 0, 0, 0, 1, 1, 4, 15);
        cycles("os_resume", 3);

        // Same-edge clr/load/en at 7
        drive(0, 0, 1, 7, 1, 0, 12, 15);
        cycles("prio_load7", 1);
        drive(1, 1, 1, 11, 1, 0, 12, 15);
        cycles("prio_clr", 1);
        check("prio_clr_const", 32'(counter_o), 32'(RSTV));

        // Compare match with hold at 3
        drive(0, 0, 1, 0, 1, 0, 6, 3);
        cycles("cmp_load", 1);
        drive(1, 0, 0, 0, 1, 0, 6, 3);
        cycles("cmp_run", 3);
        drive(0, 0, 0, 0, 1, 0, 6, 3);
        cycles("cmp_hold", 3);
        check("cmp_hold_const", 32'(cmp_match_o), 32'd1);
        drive(1, 0, 0, 0, 1, 0, 6, 3);
        cycles("cmp_resume", 9);

        // max 0 in wrap: tc every enabled cycle
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        cycles("max0_load", 1);
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        cycles("max0_up", 3);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycles("max0_dn", 3);

        // Async reset mid-count at 5 in one-shot
        drive(0, 0, 1, 0, 1, 1, 10, 5);
        cycles("ar_load", 1);
        drive(1, 0, 0, 0, 1, 1, 10, 5);
        cycles("ar_run", 5);
        async_reset("ar_mid");
        cycles("ar_restart", 4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  (i % 50 < 10) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd_arst");
            end else begin
                cycles("rnd", 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mode_counter
